// File: rtl/box_filter.sv
// box_filter: streaming 2x2 box filter over a raster-order pixel stream.
// Each valid pixel is averaged with its left, up and up-left neighbours,
// with edge replication on row 0 and column 0. The output is registered
// with one cycle of latency. i_mode selects pass-through (0) or mean (1).
// Optional build macro BOX_FILTER_ROUND_EN: when defined the mean is rounded
// half up ((sum+2)>>2); otherwise it is truncated (sum>>2).
module box_filter #(
    parameter int DATA_WIDTH = 12,
    parameter int ROW_LENGTH = 1280,
    parameter int ROW_COUNT  = 960
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sof,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_mode,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_eof
);

    localparam int COL_W = $clog2(ROW_LENGTH);
    localparam int ROW_W = $clog2(ROW_COUNT);
    localparam int SUM_W = DATA_WIDTH + 2;

    // Raster position of the next expected pixel
    logic [COL_W-1:0]      col_reg;
    logic [ROW_W-1:0]      row_reg;

    // Position of the pixel on i_data this cycle and of the one after it
    logic [COL_W-1:0]      cur_col;
    logic [ROW_W-1:0]      cur_row;
    logic [COL_W-1:0]      col_next;
    logic [ROW_W-1:0]      row_next;
    logic                  last_col;
    logic                  last_row;

    // Line buffer (one row of history) with a registered read port
    logic [DATA_WIDTH-1:0] line_mem [ROW_LENGTH];
    logic [DATA_WIDTH-1:0] up_reg;

    // Horizontal history: previous pixel and previous line-buffer output
    logic [DATA_WIDTH-1:0] left_reg;
    logic [DATA_WIDTH-1:0] upleft_reg;

    // Window taps after edge substitution
    logic [DATA_WIDTH-1:0] left_tap;
    logic [DATA_WIDTH-1:0] up_tap;
    logic [DATA_WIDTH-1:0] upleft_tap;

    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      sum_adj;
    logic [DATA_WIDTH-1:0] mean;
    logic [DATA_WIDTH-1:0] data_next;

    logic                  valid_reg;
    logic                  eof_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    // Current pixel position: start of frame forces (0,0) for this pixel
    always_comb begin
        cur_col  = col_reg;
        cur_row  = row_reg;
        if (i_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
        last_col = (cur_col == COL_W'(ROW_LENGTH - 1));
        last_row = (cur_row == ROW_W'(ROW_COUNT - 1));
        col_next = last_col ? '0 : cur_col + COL_W'(1);
        row_next = cur_row;
        if (last_col) begin
            row_next = last_row ? '0 : cur_row + ROW_W'(1);
        end
    end

    // Line buffer: store the current pixel at its column and prefetch the
    // previous row's pixel for the column that follows. Read and write
    // addresses always differ because a row holds at least two pixels.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            line_mem[cur_col] <= i_data;
            up_reg            <= line_mem[col_next];
        end
    end

    // Window formation with row-0 then col-0 replication, and the mean
    always_comb begin
        up_tap     = up_reg;
        upleft_tap = upleft_reg;
        left_tap   = left_reg;
        if (cur_row == '0) begin
            up_tap     = i_data;
            upleft_tap = left_reg;
        end
        if (cur_col == '0) begin
            left_tap   = i_data;
            upleft_tap = up_tap;
        end
        sum = SUM_W'(i_data) + SUM_W'(left_tap) + SUM_W'(up_tap) + SUM_W'(upleft_tap);
`ifdef BOX_FILTER_ROUND_EN
        // Max sum is 2^SUM_W - 4, so adding 2 cannot overflow
        sum_adj = sum + SUM_W'(2);
`else
        sum_adj = sum;
`endif
        mean      = sum_adj[SUM_W-1:2];
        data_next = i_mode ? mean : i_data;
    end

    // Position counters, horizontal history and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_reg    <= '0;
            row_reg    <= '0;
            left_reg   <= '0;
            upleft_reg <= '0;
            valid_reg  <= 1'b0;
            eof_reg    <= 1'b0;
            data_reg   <= '0;
        end else begin
            valid_reg <= i_valid;
            eof_reg   <= i_valid && last_col && last_row;
            if (i_valid) begin
                data_reg   <= data_next;
                left_reg   <= i_data;
                upleft_reg <= up_reg;
                col_reg    <= col_next;
                row_reg    <= row_next;
            end else if (i_sof) begin
                col_reg <= '0;
                row_reg <= '0;
            end
        end
    end

    assign o_valid = valid_reg;
    assign o_eof   = eof_reg;
    assign o_data  = data_reg;

endmodule

// File: tb/tb_box_filter.sv
// tb_box_filter: randomized and directed stimulus for box_filter, checked
// against a frame-array reference model of the 2x2 mean with edge replication.
module tb_box_filter;

    localparam int DW = 12;
    localparam int RL = 4;
    localparam int RC = 3;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_sof = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_mode = 1'b0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_eof;

    always #5 i_clk = ~i_clk;

    box_filter #(
        .DATA_WIDTH(DW),
        .ROW_LENGTH(RL),
        .ROW_COUNT (RC)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_sof  (i_sof),
        .i_valid(i_valid),
        .i_data (i_data),
        .i_mode (i_mode),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_eof  (o_eof)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: pixels of the current frame by position
    int img [RC][RL];
    int mr = 0;
    int mc = 0;
    int hold_data = 0;
    int seen_valid = 0;
    int seen_eof = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mean of the 2x2 neighbourhood ending at (r,c) with replicated edges
    function automatic int ref_mean(input int r, input int c);
        int cur, lft, up, ul, sum;
        cur = img[r][c];
        lft = (c > 0) ? img[r][c-1] : cur;
        up  = (r > 0) ? img[r-1][c] : cur;
        if (r > 0 && c > 0) ul = img[r-1][c-1];
        else if (c > 0)     ul = lft;
        else                ul = up;
        sum = cur + lft + up + ul;
`ifdef BOX_FILTER_ROUND_EN
        return (sum + 2) / 4;
`else
        return sum / 4;
`endif
    endfunction

    // One clock of stimulus followed by a check of the registered outputs
    task automatic cycle(input bit sof, input bit valid, input int data, input bit mode, input string tag);
        bit exp_eof;
        @(negedge i_clk);
        i_sof   = sof;
        i_valid = valid;
        i_data  = DW'(data);
        i_mode  = mode;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        exp_eof = 1'b0;
        if (valid) begin
            img[mr][mc] = data % (1 << DW);
            hold_data   = mode ? ref_mean(mr, mc) : img[mr][mc];
            exp_eof     = (mr == RC - 1) && (mc == RL - 1);
            if (mc == RL - 1) begin
                mc = 0;
                mr = (mr == RC - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
        @(posedge i_clk);
        #1;
        if (o_valid) seen_valid++;
        if (o_eof)   seen_eof++;
        $display("%s sof=%0b vld=%0b din=0x%0h mode=%0b -> o_valid=%0b o_data=0x%0h o_eof=%0b",
                 tag, sof, valid, DW'(data), mode, o_valid, o_data, o_eof);
        check_val({tag, "_valid"}, 32'(o_valid), 32'(valid));
        check_val({tag, "_data"},  32'(o_data),  32'(hold_data));
        check_val({tag, "_eof"},   32'(o_eof),   32'(exp_eof));
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        @(negedge i_clk);
        i_sof   = 1'b0;
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_val({tag, "_rst_valid"}, 32'(o_valid), 32'd0);
        check_val({tag, "_rst_data"},  32'(o_data),  32'd0);
        check_val({tag, "_rst_eof"},   32'(o_eof),   32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        mr        = 0;
        mc        = 0;
        hold_data = 0;
    endtask

    initial begin
        int frame_pix;
        // Reset state
        repeat (2) @(posedge i_clk);
        do_reset("init");

        // First pixel replicated into all four taps
        cycle(1, 1, 'h123, 1, "first");
        cycle(0, 0, 0, 1, "first_idle");

        // Interior averaging: row0 10..40, row1 50..80
        for (int i = 0; i < RL; i++) cycle(i == 0, 1, 10 * (i + 1), 1, "avg_r0");
        for (int i = 0; i < RL; i++) cycle(0, 1, 50 + 10 * i, 1, "avg_r1");

        // Rounding: (1,1) taps 1,1,1,2 and (1,2) taps 1,1,2,2
        for (int i = 0; i < RL; i++) cycle(i == 0, 1, 1, 1, "rnd_r0");
        cycle(0, 1, 1, 1, "rnd_r1");
        cycle(0, 1, 2, 1, "rnd_r1");
        cycle(0, 1, 2, 1, "rnd_r1");
        cycle(0, 1, 1, 1, "rnd_r1");

        // Stalls and end of frame: valid toggling across a whole frame
        cycle(1, 0, 0, 1, "stall_sof");
        seen_valid = 0;
        seen_eof   = 0;
        for (int i = 0; i < RL * RC; i++) begin
            cycle(0, 1, $urandom_range(0, (1 << DW) - 1), 1, "stall");
            cycle(0, 0, $urandom_range(0, (1 << DW) - 1), 1, "stall_gap");
        end
        check_val("stall_pulses", 32'(seen_valid), 32'(RL * RC));
        check_val("stall_eofs",   32'(seen_eof),   32'd1);

        // Mode switch: pass-through on row0, mean from row1 col0
        for (int i = 0; i < RL; i++) cycle(i == 0, 1, $urandom_range(0, (1 << DW) - 1), 0, "mode_r0");
        for (int i = 0; i < RL; i++) cycle(0, 1, $urandom_range(0, (1 << DW) - 1), 1, "mode_r1");

        // Reset mid-frame at row1 col2, then a fresh first pixel
        for (int i = 0; i < RL + 2; i++) cycle(i == 0, 1, 'h400 + 37 * i, 1, "mid");
        do_reset("mid");
        cycle(0, 1, 'h800, 1, "after_rst");
        cycle(0, 1, 'h100, 1, "after_rst");

        // Randomized frames with stalls, mode changes and idle start-of-frame
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                cycle(1, 0, 0, 0, "rnd_sof");
                frame_pix = 0;
            end else begin
                cycle(1, 1, $urandom_range(0, (1 << DW) - 1), $urandom_range(0, 1), "rnd_sof");
                frame_pix = 1;
            end
            while (frame_pix < RL * RC) begin
                bit v;
                v = ($urandom_range(0, 9) < 7);
                cycle(0, v, $urandom_range(0, (1 << DW) - 1), $urandom_range(0, 1), "rnd");
                if (v) frame_pix++;
            end
        end
        // Extreme values: all-ones frame must not overflow
        for (int i = 0; i < RL * RC; i++) cycle(i == 0, 1, (1 << DW) - 1, 1, "max");
        cycle(0, 0, 0, 1, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/box_filter.md
BOX_FILTER -- requirements
Module: box_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: pixel width in bits, minimum 2.
REQ-002 SHALL have parameter ROW_LENGTH, default 1280: pixels per row, minimum 2.
REQ-003 SHALL have parameter ROW_COUNT, default 960: rows per frame, minimum 2.
REQ-004 SHALL have port i_clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_sof  input  1: start of frame; the current or next valid pixel is (row 0, col 0).
REQ-007 SHALL have port i_valid  input  1: i_data carries a pixel this cycle.
REQ-008 SHALL have port i_data  input  DATA_WIDTH: pixel, raster order.
REQ-009 SHALL have port i_mode  input  1: 0 = pass-through, 1 = 2x2 mean.
REQ-010 SHALL have port o_valid  output  1: o_data valid this cycle.
REQ-011 SHALL have port o_data  output  DATA_WIDTH: filtered pixel.
REQ-012 SHALL have port o_eof  output  1: o_data is the last pixel of a frame, (ROW_COUNT-1, ROW_LENGTH-1).

Function
REQ-013 SHALL hold a ROW_LENGTH-deep, DATA_WIDTH-wide line buffer that advances only on cycles where i_valid=1.
REQ-014 SHALL form the window from i_data (cur), the previous valid pixel (left), the line-buffer output (up) and the previous line-buffer output (upleft).
REQ-015 SHALL track col (0..ROW_LENGTH-1) and row (0..ROW_COUNT-1); col increments per valid pixel and wraps to 0, incrementing row; row wraps to 0 after ROW_COUNT-1.
REQ-016 SHALL, when i_sof=1 and i_valid=1 together, treat that pixel as (0,0); when i_sof=1 and i_valid=0, make the next valid pixel (0,0).
REQ-017 SHALL, at row 0, substitute up with cur and upleft with left.
REQ-018 SHALL, at col 0, substitute left with cur and upleft with up, after REQ-017; pixel (0,0) therefore uses cur for all four taps.
REQ-019 SHALL compute the sum of the four taps at DATA_WIDTH+2 bits with no overflow; the mean is sum>>2, or the rounded form of REQ-029.
REQ-020 SHALL drive o_data with i_data when i_mode=0 and with the mean when i_mode=1; i_mode is sampled with each valid pixel.
REQ-021 SHALL register o_data, o_valid and o_eof with exactly 1 cycle of latency: o_valid(t+1)=i_valid(t).
REQ-022 SHALL hold o_data unchanged while o_valid=0, and drive o_eof=0 whenever o_valid=0.
REQ-023 SHALL keep the line buffer and counters updating in both modes, so that switching mode needs no refill.

Reset
REQ-024 SHALL clear o_valid, o_eof, o_data, col, row and the left/upleft registers to 0 on an i_rst_n assertion, immediately and without waiting for a clock.
REQ-025 SHALL place no requirement on the line-buffer contents after reset; the row-0 substitution of REQ-017 hides them.
REQ-026 SHALL, after reset is released mid-frame, treat the next valid pixel as (0,0).

Configuration
REQ-027 SHALL use the macro BOX_FILTER_ROUND_EN.
REQ-028 SHALL, without the macro, compute mean = sum>>2 (truncation).
REQ-029 SHALL, with the macro defined, compute mean = (sum+2)>>2 (round half up) in DATA_WIDTH+2 bits; the result never exceeds 2^DATA_WIDTH-1.

Verification (DATA_WIDTH=12, ROW_LENGTH=4, ROW_COUNT=3 unless stated)
REQ-030 SHALL cover first-pixel replicate: reset, then i_sof=1, i_valid=1, i_data=0x123, i_mode=1 -> next cycle o_valid=1, o_data=0x123, o_eof=0.
REQ-031 SHALL cover interior averaging: row0 = 10,20,30,40, then row1 = 50,60,70,80, mode 1, no macro -> row1 outputs 30,35,45,55 (col 0 is (50+50+10+10)/4).
REQ-032 SHALL cover rounding: interior taps 1,1,1,2 -> o_data=1 without the macro, 1 with it; taps 1,1,2,2 -> 1 without, 2 with.
REQ-033 SHALL cover stalls and end of frame: 12 pixels with i_valid toggling 1,0 -> 12 o_valid pulses, each 1 cycle after its input, o_data stable between pulses, o_eof=1 only on the 12th.
REQ-034 SHALL cover the pass-through/mode switch: mode 0 across row0, mode 1 from row1 col 0 -> row0 outputs equal the inputs; row1 outputs average against the buffered row0 values.
REQ-035 SHALL cover reset mid-frame: assert i_rst_n=0 at row 1 col 2 -> outputs 0 immediately; after release, the first valid pixel 0x800 in mode 1 -> o_data=0x800.
